wide_out_packer: RTL and testbench
==================================

// Module: wide_out_packer
// PURPOSE
//  Sink for the byte-wide pixel writes (out_waddr/out_wdata/out_we) of bilinear_seq_wide (lane 0 only)
//  and bilinear_simd4_wide (lanes 0-3). Packs the bytes into 32-bit words (4 px/word) and issues them to a
//  wide_onchip_mem instance over the req/resp handshake. Partial words go through read-modify-write.
//  Sits in the top between the active core (muxed by mode) and the output RAM.
// PARAMETERS
//  AW       18  width of the pixel (byte) address in; the memory word address is zero-extended {2'b0, waddr[AW-1:2]}
//  OUT_BASE 0   word offset added to every memory address (mod 2^AW)
//  CNT_W    32  width of wr_count
// PORTS
//  clk_50         in   1        clock
//  rst_n          in   1        asynchronous reset, active-low
//  in_we          in   4        per-lane byte write strobe (lane i = bit i)
//  in_waddr       in   4xAW     per-lane pixel address
//  in_wdata       in   4x8      per-lane pixel value
//  in_ready       out  1        lane set accepted this cycle when 1
//  flush          in   1        pulse: write out any partial word
//  flush_done     out  1        1-cycle pulse: flush complete, buffer empty, no request pending
//  mem_req_valid  out  1        request valid
//  mem_req_ready  in   1        request accepted
//  mem_req_we     out  1        1 = write, 0 = read
//  mem_req_addr   out  AW       word address
//  mem_req_wdata  out  32       write data; byte k (bits 8k+7:8k) = pixel at waddr[1:0]=k
//  mem_resp_valid in   1        read data valid
//  mem_resp_rdata in   32       read data
//  busy           out  1        buffer non-empty, or state != S_ACC
//  err_drop       out  1        sticky: in_we!=0 while in_ready=0
//  wr_count       out  CNT_W    words written; wraps
// BEHAVIOUR
//  Reset:
//  - All outputs 0, except in_ready=1.
//  - state=S_ACC; word buffer (wbuf, waddr_buf, mask) cleared.
//  - Any in-flight memory transaction is abandoned.
//  States: S_ACC, S_SER, S_WR_REQ, S_RD_REQ, S_RD_WAIT.
//  - S_ACC: in_ready=1.
//    - Fast path: all active lanes map to one word W, and mask==0 or W==waddr_buf.
//      Merge into wbuf the same cycle. Lanes merge in ascending order, so a higher lane wins on a duplicate byte.
//    - Otherwise: latch the lane set into the stage registers and go to S_SER.
//  - S_SER: in_ready=0. Process one staged lane per cycle in ascending order.
//    - If the lane's word differs from a non-empty buffer, flush the buffer first, then merge.
//  - Flush routing:
//    - mask==4'hF: go to S_WR_REQ.
//    - mask partial: go to S_RD_REQ (read same word) -> S_RD_WAIT.
//      On mem_resp_valid, merge: buffer bytes override read bytes. Then go to S_WR_REQ.
//  - S_WR_REQ: mem_req_valid=1 and mem_req_we=1; addr and wdata held stable until mem_req_ready.
//    - On the handshake: wr_count++, buffer cleared.
//    - Next state: S_SER if staged lanes remain, else S_ACC.
//    - Writes complete on the handshake; no response is expected.
//  - mem_resp_valid outside S_RD_WAIT is ignored.
//  - Full-word trigger: when mask reaches 4'hF (either path), the next state is S_WR_REQ. Latency is 1 cycle
//    from merge to mem_req_valid.
//  - Latency: mem_req_valid goes high the cycle after the flush decision. No combinational path from
//    mem_req_ready to mem_req_valid.
//  - in_ready is 0 in every state except S_ACC. in_we!=0 while in_ready=0 sets err_drop, and the data is dropped.
//  - flush:
//    - Latched as pending; serviced once state=S_ACC and the stage is empty.
//    - Empty buffer: flush_done the next cycle.
//    - Partial buffer: flush_done the cycle after the write handshake.
//    - If flush arrives in the same cycle as an accepted lane set, the lanes merge first, then the flush runs.
//  - Address arithmetic: mem_req_addr = OUT_BASE + word, mod 2^AW.
// STRUCTURE
//  - Package dsa_out_pkg:
//    - state enum out_state_e
//    - struct lane_wr_t {we, waddr, wdata}
//    - constants LANES=4, BYTES_PER_WORD=4
//    - function merge_bytes(old32, new32, mask4)
//  - Single module, no sub-module. The stage registers are 4x lane_wr_t plus a lane pointer.
// TESTING
//  1. Lanes 0-3 write addr 0,1,2,3 with data 11,22,33,44 (hex); ready=1 -> one write, addr 0, wdata 0x44332211,
//     wr_count=1.
//  2. Lane 0 writes addr 5=0xAA, then flush -> read addr 1; respond 0xDEADBEEF -> write addr 1, wdata 0xDEADAAEF;
//     then flush_done.
//  3. Lanes write addr 6,7,8,9 -> in_ready=0 during S_SER; RMW write to word 1 (bytes 2,3); word 2 stays buffered;
//     flush -> RMW write to word 2.
//  4. in_we=4'h1 while in_ready=0 -> err_drop=1; stays 1 until rst_n.
//  5. mem_req_ready held 0 for 10 cycles in S_WR_REQ -> valid, addr and wdata stable throughout; one write on
//     release.
//  6. rst_n asserted during S_RD_WAIT -> all outputs 0 and in_ready=1 immediately; a later resp_valid is ignored.

Source files
------------

// File: rtl/dsa_out_pkg.sv
// Shared types for the wide output packer: FSM states, staged lane record, byte merge helper.
package dsa_out_pkg;
  localparam int LANES          = 4;
  localparam int BYTES_PER_WORD = 4;
  localparam int ADDR_MAX       = 32;

  typedef enum logic [2:0] {S_ACC, S_SER, S_WR_REQ, S_RD_REQ, S_RD_WAIT} out_state_e;

  typedef struct packed {
    logic                we;
    logic [ADDR_MAX-1:0] waddr;
    logic [7:0]          wdata;
  } lane_wr_t;

  // Bytes flagged in mask4 come from new32, the rest from old32.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old32, input logic [31:0] new32,
                                              input logic [3:0] mask4);
    logic [31:0] r;
    for (int k = 0; k < BYTES_PER_WORD; k++)
      r[8*k +: 8] = mask4[k] ? new32[8*k +: 8] : old32[8*k +: 8];
    return r;
  endfunction
endpackage

// File: rtl/wide_out_packer.sv
// Packs per-lane byte pixel writes into 32-bit memory words; partial words are written by read-modify-write.
module wide_out_packer
  import dsa_out_pkg::*;
#(
  parameter int AW       = 18,
  parameter int OUT_BASE = 0,
  parameter int CNT_W    = 32
) (
  input  logic                      clk_50,
  input  logic                      rst_n,
  input  logic [LANES-1:0]          in_we,
  input  logic [LANES-1:0][AW-1:0]  in_waddr,
  input  logic [LANES-1:0][7:0]     in_wdata,
  output logic                      in_ready,
  input  logic                      flush,
  output logic                      flush_done,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic                      mem_req_we,
  output logic [AW-1:0]             mem_req_addr,
  output logic [31:0]               mem_req_wdata,
  input  logic                      mem_resp_valid,
  input  logic [31:0]               mem_resp_rdata,
  output logic                      busy,
  output logic                      err_drop,
  output logic [CNT_W-1:0]          wr_count
);
  out_state_e          state_q;
  logic [31:0]         wbuf_q;
  logic [AW-3:0]       waddr_buf_q;
  logic [3:0]          mask_q;
  lane_wr_t [LANES-1:0] stage_q;
  logic                fpend_q, fdone_q, err_q;
  logic [CNT_W-1:0]    cnt_q;

  // fast-path decode of the incoming lane set
  logic [AW-3:0] fw;
  logic          f_found, same, fast_ok;
  logic [31:0]   fdata;
  logic [3:0]    fmask;
  // next staged lane
  logic [LANES-1:0] rem, rem_after;
  logic [1:0]       sel;
  logic             s_found;
  logic [AW-3:0]    sl_word;
  logic [1:0]       sl_byte;
  logic [7:0]       sl_data;
  logic [3:0]       smask;

  always_comb begin
    fw = '0; f_found = 1'b0; same = 1'b1; fdata = wbuf_q; fmask = mask_q;
    for (int i = 0; i < LANES; i++)
      if (in_we[i] && !f_found) begin
        fw = in_waddr[i][AW-1:2];
        f_found = 1'b1;
      end
    for (int i = 0; i < LANES; i++)
      if (in_we[i]) begin
        if (in_waddr[i][AW-1:2] != fw) same = 1'b0;
        fdata[8*in_waddr[i][1:0] +: 8] = in_wdata[i];
        fmask[in_waddr[i][1:0]] = 1'b1;
      end
    fast_ok = (in_we != '0) && same && (mask_q == '0 || fw == waddr_buf_q);

    sel = '0; s_found = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      rem[i] = stage_q[i].we;
      if (stage_q[i].we && !s_found) begin
        sel = 2'(i);
        s_found = 1'b1;
      end
    end
    rem_after = rem;
    rem_after[sel] = 1'b0;
    sl_word = stage_q[sel].waddr[AW-1:2];
    sl_byte = stage_q[sel].waddr[1:0];
    sl_data = stage_q[sel].wdata;
    smask   = mask_q | (4'b0001 << sl_byte);
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_ACC;
      wbuf_q      <= '0;
      waddr_buf_q <= '0;
      mask_q      <= '0;
      stage_q     <= '0;
      fpend_q     <= 1'b0;
      fdone_q     <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      fdone_q <= 1'b0;
      if (flush) fpend_q <= 1'b1;
      if (in_we != '0 && state_q != S_ACC) err_q <= 1'b1;
      case (state_q)
        S_ACC:
          if (in_we != '0) begin
            // lanes take priority; a coincident flush stays pending
            if (fast_ok) begin
              wbuf_q      <= fdata;
              mask_q      <= fmask;
              waddr_buf_q <= fw;
              if (fmask == 4'hF) state_q <= S_WR_REQ;
            end else begin
              for (int i = 0; i < LANES; i++) begin
                stage_q[i].we    <= in_we[i];
                stage_q[i].waddr <= ADDR_MAX'(in_waddr[i]);
                stage_q[i].wdata <= in_wdata[i];
              end
              state_q <= S_SER;
            end
          end else if (flush || fpend_q) begin
            if (mask_q == '0) begin
              fdone_q <= 1'b1;
              fpend_q <= 1'b0;
            end else begin
              state_q <= (mask_q == 4'hF) ? S_WR_REQ : S_RD_REQ;
            end
          end
        S_SER:
          if (rem == '0) state_q <= S_ACC;
          else if (mask_q != '0 && sl_word != waddr_buf_q)
            state_q <= (mask_q == 4'hF) ? S_WR_REQ : S_RD_REQ;
          else begin
            wbuf_q[8*sl_byte +: 8] <= sl_data;
            mask_q                 <= smask;
            waddr_buf_q            <= sl_word;
            stage_q[sel].we        <= 1'b0;
            if (smask == 4'hF)        state_q <= S_WR_REQ;
            else if (rem_after == '0) state_q <= S_ACC;
          end
        S_WR_REQ:
          if (mem_req_ready) begin
            cnt_q       <= cnt_q + 1'b1;
            wbuf_q      <= '0;
            mask_q      <= '0;
            waddr_buf_q <= '0;
            state_q     <= (rem != '0) ? S_SER : S_ACC;
            if (rem == '0 && fpend_q) begin
              fdone_q <= 1'b1;
              fpend_q <= 1'b0;
            end
          end
        S_RD_REQ:
          if (mem_req_ready) state_q <= S_RD_WAIT;
        S_RD_WAIT:
          if (mem_resp_valid) begin
            wbuf_q  <= merge_bytes(mem_resp_rdata, wbuf_q, mask_q);
            mask_q  <= 4'hF;
            state_q <= S_WR_REQ;
          end
        default: state_q <= S_ACC;
      endcase
    end
  end

  // upper address bits of the stage records are always zero
  logic unused_stage;
  assign unused_stage = ^stage_q;

  assign in_ready      = (state_q == S_ACC);
  assign mem_req_valid = (state_q == S_WR_REQ) || (state_q == S_RD_REQ);
  assign mem_req_we    = (state_q == S_WR_REQ);
  assign mem_req_addr  = AW'(OUT_BASE) + {2'b00, waddr_buf_q};
  assign mem_req_wdata = wbuf_q;
  assign busy          = (mask_q != '0) || (state_q != S_ACC);
  assign err_drop      = err_q;
  assign wr_count      = cnt_q;
  assign flush_done    = fdone_q;
endmodule

// File: tb/tb_wide_out_packer.sv
// Directed bench for wide_out_packer: full words, RMW flushes, serialisation, backpressure, reset abort.
module tb_wide_out_packer;
  localparam int AW = 18;

  logic                clk_50 = 1'b0;
  logic                rst_n  = 1'b0;
  logic [3:0]          in_we;
  logic [3:0][AW-1:0]  in_waddr;
  logic [3:0][7:0]     in_wdata;
  logic                in_ready, flush, flush_done;
  logic                mem_req_valid, mem_req_ready, mem_req_we;
  logic [AW-1:0]       mem_req_addr;
  logic [31:0]         mem_req_wdata, mem_resp_rdata;
  logic                mem_resp_valid, busy, err_drop;
  logic [31:0]         wr_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_50 = ~clk_50;

  wide_out_packer #(.AW(AW), .OUT_BASE(0), .CNT_W(32)) dut (
    .clk_50(clk_50), .rst_n(rst_n),
    .in_we(in_we), .in_waddr(in_waddr), .in_wdata(in_wdata), .in_ready(in_ready),
    .flush(flush), .flush_done(flush_done),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .busy(busy), .err_drop(err_drop), .wr_count(wr_count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] we, input logic [3:0][AW-1:0] a, input logic [3:0][7:0] d);
    in_we = we; in_waddr = a; in_wdata = d;
    @(negedge clk_50);
    in_we = '0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(negedge clk_50);
    flush = 1'b0;
  endtask

  task automatic resp(input logic [31:0] d);
    mem_resp_valid = 1'b1; mem_resp_rdata = d;
    @(negedge clk_50);
    mem_resp_valid = 1'b0;
  endtask

  // waits (bounded) for a request, checks it, then completes one handshake
  task automatic wait_req(input string tag, input logic we, input logic [AW-1:0] addr,
                          input logic [31:0] wd, input bit chkd);
    int n = 0;
    while (!mem_req_valid && n < 50) begin
      @(negedge clk_50);
      n++;
    end
    chk({tag, " valid"}, 64'(mem_req_valid), 64'd1);
    chk({tag, " we"}, 64'(mem_req_we), 64'(we));
    chk({tag, " addr"}, 64'(mem_req_addr), 64'(addr));
    if (chkd) chk({tag, " wdata"}, 64'(mem_req_wdata), 64'(wd));
    mem_req_ready = 1'b1;
    @(negedge clk_50);
    mem_req_ready = 1'b0;
  endtask

  initial begin
    in_we = '0; in_waddr = '0; in_wdata = '0; flush = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    repeat (2) @(negedge clk_50);
    chk("rst in_ready", 64'(in_ready), 64'd1);
    chk("rst req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst wr_count", 64'(wr_count), 64'd0);
    chk("rst flush_done", 64'(flush_done), 64'd0);
    rst_n = 1'b1;
    @(negedge clk_50);

    // 1: one full word via the fast path
    drive(4'hF, {18'd3, 18'd2, 18'd1, 18'd0}, {8'h44, 8'h33, 8'h22, 8'h11});
    wait_req("t1 wr", 1'b1, 18'd0, 32'h44332211, 1'b1);
    chk("t1 wr_count", 64'(wr_count), 64'd1);

    // 2: single byte, flush -> RMW
    drive(4'h1, {18'd0, 18'd0, 18'd0, 18'd5}, {8'h00, 8'h00, 8'h00, 8'hAA});
    chk("t2 busy", 64'(busy), 64'd1);
    pulse_flush();
    wait_req("t2 rd", 1'b0, 18'd1, 32'h0, 1'b0);
    resp(32'hDEADBEEF);
    wait_req("t2 wr", 1'b1, 18'd1, 32'hDEADAAEF, 1'b1);
    chk("t2 flush_done", 64'(flush_done), 64'd1);
    @(negedge clk_50);
    chk("t2 flush_done pulse", 64'(flush_done), 64'd0);

    // 3: lanes straddling two words are serialised; 4: drop while busy
    drive(4'hF, {18'd9, 18'd8, 18'd7, 18'd6}, {8'h99, 8'h88, 8'h77, 8'h66});
    chk("t3 in_ready ser", 64'(in_ready), 64'd0);
    chk("t4 err pre", 64'(err_drop), 64'd0);
    in_we = 4'h1;
    @(negedge clk_50);
    in_we = '0;
    chk("t4 err_drop", 64'(err_drop), 64'd1);
    wait_req("t3 rd1", 1'b0, 18'd1, 32'h0, 1'b0);
    resp(32'h12345678);
    wait_req("t3 wr1", 1'b1, 18'd1, 32'h77665678, 1'b1);
    repeat (3) @(negedge clk_50);
    chk("t3 in_ready acc", 64'(in_ready), 64'd1);
    chk("t3 busy buffered", 64'(busy), 64'd1);
    chk("t3 no req", 64'(mem_req_valid), 64'd0);
    pulse_flush();
    wait_req("t3 rd2", 1'b0, 18'd2, 32'h0, 1'b0);
    resp(32'hCAFEF00D);
    wait_req("t3 wr2", 1'b1, 18'd2, 32'hCAFE9988, 1'b1);
    chk("t3 flush_done", 64'(flush_done), 64'd1);
    chk("t3 wr_count", 64'(wr_count), 64'd4);
    chk("t4 err sticky", 64'(err_drop), 64'd1);

    // 5: backpressure on a full-word write
    drive(4'hF, {18'd15, 18'd14, 18'd13, 18'd12}, {8'h04, 8'h03, 8'h02, 8'h01});
    for (int i = 0; i < 10; i++) begin
      chk("t5 hold valid", 64'(mem_req_valid), 64'd1);
      chk("t5 hold addr", 64'(mem_req_addr), 64'd3);
      chk("t5 hold wdata", 64'(mem_req_wdata), 64'h04030201);
      @(negedge clk_50);
    end
    wait_req("t5 wr", 1'b1, 18'd3, 32'h04030201, 1'b1);
    chk("t5 wr_count", 64'(wr_count), 64'd5);
    chk("t5 single write", 64'(mem_req_valid), 64'd0);

    // 6: reset while waiting for read data
    drive(4'h1, {18'd0, 18'd0, 18'd0, 18'd20}, {8'h00, 8'h00, 8'h00, 8'h5A});
    pulse_flush();
    wait_req("t6 rd", 1'b0, 18'd5, 32'h0, 1'b0);
    chk("t6 busy pre", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t6 in_ready", 64'(in_ready), 64'd1);
    chk("t6 req_valid", 64'(mem_req_valid), 64'd0);
    chk("t6 busy", 64'(busy), 64'd0);
    chk("t6 wr_count", 64'(wr_count), 64'd0);
    chk("t6 err_drop", 64'(err_drop), 64'd0);
    chk("t6 addr", 64'(mem_req_addr), 64'd0);
    chk("t6 wdata", 64'(mem_req_wdata), 64'd0);
    @(negedge clk_50);
    rst_n = 1'b1;
    @(negedge clk_50);
    resp(32'hFFFFFFFF);
    chk("t6 late resp valid", 64'(mem_req_valid), 64'd0);
    chk("t6 late resp busy", 64'(busy), 64'd0);
    @(negedge clk_50);
    chk("t6 late resp valid2", 64'(mem_req_valid), 64'd0);
    chk("t6 late wr_count", 64'(wr_count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end
endmodule
